// File: rtl/bcd_stopwatch_ctrl_if.sv
// Command and display bundle between the stopwatch controller
// and its neighbours (debouncer upstream, 7-seg mux downstream).
interface bcd_stopwatch_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  start_stop;
    logic                  clear;
    logic                  lap;
    logic [4*DIGITS-1:0]   digits_out;
    logic                  running;
    logic                  lap_active;
    logic                  overflow;

    modport master (
        output start_stop, clear, lap,
        input  digits_out, running, lap_active, overflow
    );

    modport slave (
        input  start_stop, clear, lap,
        output digits_out, running, lap_active, overflow
    );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// Start/stop/lap stopwatch over a chain of BCD digits with a
// tick prescaler, sticky wrap flag and lap display freeze.
module bcd_stopwatch_ctrl #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 500000
) (
    input  logic                clk,
    input  logic                reset,
    bcd_stopwatch_ctrl_if.slave sw
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP,
        LAP
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   presc, presc_n;
    logic [W-1:0]    count, count_n;
    logic [W-1:0]    snap, snap_n;
    logic [W-1:0]    inc;
    logic            carry;
    logic            ovf_n;
    logic            counting;
    logic            tick;

    // Whole-chain ripple increment; carry out means the chain was all 9s
    always_comb begin
        inc   = count;
        carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (count[4*k +: 4] == 4'd9) begin
                    inc[4*k +: 4] = 4'd0;
                end else begin
                    inc[4*k +: 4] = count[4*k +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
    end

    assign counting = (state == RUN) || (state == LAP);
    assign tick     = counting && (presc == LAST);

    always_comb begin
        state_n = state;
        presc_n = presc;
        count_n = count;
        snap_n  = snap;
        ovf_n   = sw.overflow;
        if (sw.clear) begin
            state_n = IDLE;
            presc_n = '0;
            count_n = '0;
            snap_n  = '0;
            ovf_n   = 1'b0;
        end else begin
            if (tick) begin
                presc_n = '0;
                count_n = inc;
                ovf_n   = sw.overflow | carry;
            end else if (counting) begin
                presc_n = presc + PW'(1);
            end
            if (sw.start_stop) begin
                unique case (state)
                    IDLE, STOP: state_n = RUN;
                    RUN, LAP:   state_n = STOP;
                    default:    state_n = IDLE;
                endcase
            end else if (sw.lap) begin
                // Snapshot takes the pre-increment count
                if (state == RUN) begin
                    state_n = LAP;
                    snap_n  = count;
                end else if (state == LAP) begin
                    state_n = RUN;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            presc         <= '0;
            count         <= '0;
            snap          <= '0;
            sw.digits_out <= '0;
            sw.running    <= 1'b0;
            sw.lap_active <= 1'b0;
            sw.overflow   <= 1'b0;
        end else begin
            state         <= state_n;
            presc         <= presc_n;
            count         <= count_n;
            snap          <= snap_n;
            sw.digits_out <= (state_n == LAP) ? snap_n : count_n;
            sw.running    <= (state_n == RUN) || (state_n == LAP);
            sw.lap_active <= (state_n == LAP);
            sw.overflow   <= ovf_n;
        end
    end
endmodule
